// File: rtl/instr_reg_sequencer.sv
// Front end of the instruction register file. It arbitrates two write requesters round-robin,
// keeps the file as a circular FIFO, and returns the oldest word through a valid/ready response.
module instr_reg_sequencer #(
    parameter int OPC_W  = 4,
    parameter int OP_W   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int IW_W   = OPC_W + 2 * OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [OPC_W-1:0]  wr0_opcode,
    input  logic [OP_W-1:0]   wr0_op_a,
    input  logic [OP_W-1:0]   wr0_op_b,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [OPC_W-1:0]  wr1_opcode,
    input  logic [OP_W-1:0]   wr1_op_a,
    input  logic [OP_W-1:0]   wr1_op_b,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [IW_W-1:0]   rd_data,
    output logic              load_en,
    output logic [ADDR_W-1:0] write_pointer,
    output logic [OPC_W-1:0]  opcode,
    output logic [OP_W-1:0]   operand_a,
    output logic [OP_W-1:0]   operand_b,
    output logic [ADDR_W-1:0] read_pointer,
    input  logic [IW_W-1:0]   instruction_word,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [1:0]        rd_state_o
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    rd_state_e         rd_state_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              prio_q, prio_d;
    logic              load_en_q;
    logic [ADDR_W-1:0] write_pointer_q;
    logic [OPC_W-1:0]  opcode_q;
    logic [OP_W-1:0]   operand_a_q, operand_b_q;
    logic [ADDR_W-1:0] read_pointer_q;
    logic [IW_W-1:0]   rd_data_q;
    logic              rd_valid_q;

    logic grant0, grant1, wr_acc, rd_req_acc, rd_done;
    logic [OPC_W-1:0] sel_opcode;
    logic [OP_W-1:0]  sel_op_a, sel_op_b;

    // Every channel transfers on the cycle where valid and ready are both high at the rising
    // edge; ready never waits on anything but registered state and the requesters' valids.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign grant1       = wr1_valid & (~wr0_valid | prio_q);
    assign grant0       = wr0_valid & ~grant1;
    assign wr0_ready    = grant0 & ~full;
    assign wr1_ready    = grant1 & ~full;
    assign wr_acc       = (grant0 | grant1) & ~full;
    assign rd_req_ready = (rd_state_q == R_IDLE) & ~empty;
    assign rd_req_acc   = rd_req_valid & rd_req_ready;
    assign rd_done      = (rd_state_q == R_RESP) & rd_valid_q & rd_ready;

    assign sel_opcode = grant1 ? wr1_opcode : wr0_opcode;
    assign sel_op_a   = grant1 ? wr1_op_a   : wr0_op_a;
    assign sel_op_b   = grant1 ? wr1_op_b   : wr0_op_b;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        prio_d   = prio_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
            // The winner hands priority to the other requester.
            prio_d   = grant0;
        end
        case ({wr_acc, rd_done})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            prio_q          <= 1'b0;
            count_q         <= '0;
            load_en_q       <= 1'b0;
            write_pointer_q <= '0;
            opcode_q        <= '0;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            prio_q    <= prio_d;
            count_q   <= count_d;
            load_en_q <= wr_acc;
            if (wr_acc) begin
                write_pointer_q <= wr_ptr_q;
                opcode_q        <= sel_opcode;
                operand_a_q     <= sel_op_a;
                operand_b_q     <= sel_op_b;
            end
        end
    end

    // rd_ptr only advances on completion, so the slot under read stays counted as occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q     <= R_IDLE;
            rd_ptr_q       <= '0;
            read_pointer_q <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_req_acc) begin
                        read_pointer_q <= rd_ptr_q;
                        rd_state_q     <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    rd_data_q  <= instruction_word;
                    rd_valid_q <= 1'b1;
                    rd_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        rd_ptr_q   <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign load_en       = load_en_q;
    assign write_pointer = write_pointer_q;
    assign opcode        = opcode_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign read_pointer  = read_pointer_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign count         = count_q;
    assign rd_state_o    = rd_state_q;

endmodule

// File: tb/tb_instr_reg_sequencer.sv
// Directed bench for instr_reg_sequencer with a 4-entry FIFO and a behavioural register file.
module tb_instr_reg_sequencer;

    localparam int OPC_W  = 4;
    localparam int OP_W   = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int IW_W   = OPC_W + 2 * OP_W;

    logic              clk;
    logic              reset;
    logic              wr0_valid, wr0_ready;
    logic [OPC_W-1:0]  wr0_opcode;
    logic [OP_W-1:0]   wr0_op_a, wr0_op_b;
    logic              wr1_valid, wr1_ready;
    logic [OPC_W-1:0]  wr1_opcode;
    logic [OP_W-1:0]   wr1_op_a, wr1_op_b;
    logic              rd_req_valid, rd_req_ready;
    logic              rd_valid, rd_ready;
    logic [IW_W-1:0]   rd_data;
    logic              load_en;
    logic [ADDR_W-1:0] write_pointer;
    logic [OPC_W-1:0]  opcode;
    logic [OP_W-1:0]   operand_a, operand_b;
    logic [ADDR_W-1:0] read_pointer;
    logic [IW_W-1:0]   instruction_word;
    logic [ADDR_W:0]   count;
    logic              full, empty;
    logic [1:0]        rd_state_o;

    int checks   = 0;
    int failures = 0;

    logic [IW_W-1:0] rf_mem [0:(1 << ADDR_W) - 1];

    instr_reg_sequencer #(
        .OPC_W(OPC_W), .OP_W(OP_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IW_W(IW_W)
    ) dut (
        .clk(clk), .reset(reset),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_opcode(wr0_opcode),
        .wr0_op_a(wr0_op_a), .wr0_op_b(wr0_op_b),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_opcode(wr1_opcode),
        .wr1_op_a(wr1_op_a), .wr1_op_b(wr1_op_b),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .count(count), .full(full), .empty(empty),
        .rd_state_o(rd_state_o)
    );

    // Clock and register file model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) rf_mem[write_pointer] <= {opcode, operand_a, operand_b};
    end
    assign instruction_word = rf_mem[read_pointer];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_valid = 0; wr0_opcode = '0; wr0_op_a = '0; wr0_op_b = '0;
        wr1_valid = 0; wr1_opcode = '0; wr1_op_a = '0; wr1_op_b = '0;
        rd_req_valid = 0; rd_ready = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic drive_wr0(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        wr0_valid = 1; wr0_opcode = opc; wr0_op_a = a; wr0_op_b = b;
    endtask

    // Scenarios
    task automatic test_reset();
        apply_reset();
        drive_wr0(4'd1, 32'd1, 32'd1);
        tick();
        tick();
        rd_req_valid = 1;
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (load_en !== 1'b0) begin failures++; $display("FAIL rst_load_en got=%0h exp=0", load_en); end
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%0h exp=0", rd_valid); end
            checks++; if (count !== 6'd0) begin failures++; $display("FAIL rst_count got=%0h exp=0", count); end
            checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0h exp=1", empty); end
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0h exp=0", full); end
            checks++; if (write_pointer !== 5'd0) begin failures++; $display("FAIL rst_write_pointer got=%0h exp=0", write_pointer); end
            checks++; if (read_pointer !== 5'd0) begin failures++; $display("FAIL rst_read_pointer got=%0h exp=0", read_pointer); end
            checks++; if (rd_state_o !== 2'd0) begin failures++; $display("FAIL rst_state got=%0h exp=0", rd_state_o); end
            tick();
        end
        idle_inputs();
        reset = 0;
        tick();
        checks++; if (load_en !== 1'b0) begin failures++; $display("FAIL rst_after_load_en got=%0h exp=0", load_en); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_after_rd_valid got=%0h exp=0", rd_valid); end
    endtask

    task automatic test_wr0_only();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_wr0(4'(i + 1), 32'(10 * (i + 1)), 32'd5);
            #1;
            checks++; if (wr0_ready !== 1'b1) begin failures++; $display("FAIL wr0_ready[%0d] got=%0h exp=1", i, wr0_ready); end
            tick();
            checks++; if (load_en !== 1'b1) begin failures++; $display("FAIL wr0_load_en[%0d] got=%0h exp=1", i, load_en); end
            checks++; if (write_pointer !== 5'(i)) begin failures++; $display("FAIL wr0_wptr[%0d] got=%0h exp=%0h", i, write_pointer, i); end
            checks++; if ({opcode, operand_a, operand_b} !== {4'(i + 1), 32'(10 * (i + 1)), 32'd5})
                begin failures++; $display("FAIL wr0_data[%0d] got=%0h/%0h/%0h exp=%0h/%0h/5", i, opcode, operand_a, operand_b, i + 1, 10 * (i + 1)); end
        end
        wr0_valid = 0;
        tick();
        checks++; if (load_en !== 1'b0) begin failures++; $display("FAIL wr0_idle_load_en got=%0h exp=0", load_en); end
        checks++; if (opcode !== 4'd3) begin failures++; $display("FAIL wr0_hold_opcode got=%0h exp=3", opcode); end
        checks++; if (count !== 6'd3) begin failures++; $display("FAIL wr0_count got=%0h exp=3", count); end
    endtask

    task automatic test_arbitration();
        logic g;
        apply_reset();
        wr0_valid = 1; wr0_opcode = 4'd4; wr0_op_a = 32'd100; wr0_op_b = 32'd1;
        wr1_valid = 1; wr1_opcode = 4'd8; wr1_op_a = 32'd200; wr1_op_b = 32'd2;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2) == 1;
            #1;
            checks++; if (wr0_ready !== ~g) begin failures++; $display("FAIL arb_wr0_ready[%0d] got=%0h exp=%0h", i, wr0_ready, ~g); end
            checks++; if (wr1_ready !== g) begin failures++; $display("FAIL arb_wr1_ready[%0d] got=%0h exp=%0h", i, wr1_ready, g); end
            checks++; if ((wr0_ready & wr1_ready) !== 1'b0) begin failures++; $display("FAIL arb_both_ready[%0d] got=1 exp=0", i); end
            tick();
            checks++; if (write_pointer !== 5'(i)) begin failures++; $display("FAIL arb_wptr[%0d] got=%0h exp=%0h", i, write_pointer, i); end
            checks++; if (opcode !== (g ? 4'd8 : 4'd4)) begin failures++; $display("FAIL arb_opcode[%0d] got=%0h exp=%0h", i, opcode, g ? 8 : 4); end
        end
        #1;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL arb_full got=%0h exp=1", full); end
        checks++; if ((wr0_ready | wr1_ready) !== 1'b0) begin failures++; $display("FAIL arb_full_ready got=1 exp=0"); end
        idle_inputs();
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_wr0(4'(i + 1), 32'(16 * (i + 1)), 32'(i));
            #1;
            checks++; if (wr0_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%0h exp=1", i, wr0_ready); end
            tick();
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0h exp=1", full); end
        checks++; if (count !== 6'd4) begin failures++; $display("FAIL fill_count got=%0h exp=4", count); end
        drive_wr0(4'd5, 32'd80, 32'd9);
        #1;
        checks++; if (wr0_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0h exp=0", wr0_ready); end
        tick();
        checks++; if (load_en !== 1'b0) begin failures++; $display("FAIL stall_load_en got=%0h exp=0", load_en); end
        rd_req_valid = 1;
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("FAIL full_rd_req_ready got=%0h exp=1", rd_req_ready); end
        tick();
        rd_req_valid = 0;
        checks++; if (read_pointer !== 5'd0) begin failures++; $display("FAIL full_rptr got=%0h exp=0", read_pointer); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL full_rd_valid got=%0h exp=1", rd_valid); end
        checks++; if (rd_data !== {4'd1, 32'd16, 32'd0}) begin failures++; $display("FAIL full_rd_data got=%0h exp=%0h", rd_data, {4'd1, 32'd16, 32'd0}); end
        rd_ready = 1;
        #1;
        checks++; if (wr0_ready !== 1'b0) begin failures++; $display("FAIL full_same_cycle_ready got=%0h exp=0", wr0_ready); end
        tick();
        rd_ready = 0;
        checks++; if (count !== 6'd3) begin failures++; $display("FAIL drain_count got=%0h exp=3", count); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL drain_full got=%0h exp=0", full); end
        #1;
        checks++; if (wr0_ready !== 1'b1) begin failures++; $display("FAIL unstall_ready got=%0h exp=1", wr0_ready); end
        tick();
        wr0_valid = 0;
        checks++; if (load_en !== 1'b1) begin failures++; $display("FAIL wrap_load_en got=%0h exp=1", load_en); end
        checks++; if (write_pointer !== 5'd0) begin failures++; $display("FAIL wrap_wptr got=%0h exp=0", write_pointer); end
        checks++; if (opcode !== 4'd5) begin failures++; $display("FAIL wrap_opcode got=%0h exp=5", opcode); end
        rd_req_valid = 1;
        tick();
        rd_req_valid = 0;
        checks++; if (read_pointer !== 5'd1) begin failures++; $display("FAIL next_rptr got=%0h exp=1", read_pointer); end
        tick();
        checks++; if (rd_data !== {4'd2, 32'd32, 32'd1}) begin failures++; $display("FAIL next_rd_data got=%0h exp=%0h", rd_data, {4'd2, 32'd32, 32'd1}); end
        rd_ready = 1;
        tick();
        rd_ready = 0;
    endtask

    task automatic test_read_backpressure();
        apply_reset();
        drive_wr0(4'd3, 32'd5, 32'd7);
        rd_req_valid = 1;
        #1;
        checks++; if (rd_req_ready !== 1'b0) begin failures++; $display("FAIL empty_rd_req_ready got=%0h exp=0", rd_req_ready); end
        tick();
        wr0_valid = 0;
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("FAIL bp_rd_req_ready got=%0h exp=1", rd_req_ready); end
        tick();
        rd_req_valid = 0;
        checks++; if (read_pointer !== 5'd0) begin failures++; $display("FAIL bp_rptr got=%0h exp=0", read_pointer); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL bp_early_valid got=%0h exp=0", rd_valid); end
        checks++; if (rd_state_o !== 2'd1) begin failures++; $display("FAIL bp_state got=%0h exp=1", rd_state_o); end
        checks++; if (rd_req_ready !== 1'b0) begin failures++; $display("FAIL bp_busy_ready got=%0h exp=0", rd_req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0h exp=1", k, rd_valid); end
            checks++; if (rd_data !== {4'd3, 32'd5, 32'd7}) begin failures++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", k, rd_data, {4'd3, 32'd5, 32'd7}); end
            checks++; if (count !== 6'd1) begin failures++; $display("FAIL bp_count[%0d] got=%0h exp=1", k, count); end
        end
        rd_ready = 1;
        tick();
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL bp_done_valid got=%0h exp=0", rd_valid); end
        checks++; if (count !== 6'd0) begin failures++; $display("FAIL bp_done_count got=%0h exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL bp_done_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        drive_wr0(4'd9, 32'd11, 32'd13);
        tick();
        wr0_valid = 0;
        rd_req_valid = 1;
        tick();
        rd_req_valid = 0;
        checks++; if (rd_state_o !== 2'd1) begin failures++; $display("FAIL mid_state got=%0h exp=1", rd_state_o); end
        #1;
        reset = 1;
        #1;
        checks++; if (rd_state_o !== 2'd0) begin failures++; $display("FAIL mid_rst_state got=%0h exp=0", rd_state_o); end
        checks++; if (count !== 6'd0) begin failures++; $display("FAIL mid_rst_count got=%0h exp=0", count); end
        tick();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_no_valid[%0d] got=%0h exp=0", k, rd_valid); end
        end
        drive_wr0(4'd6, 32'd22, 32'd44);
        tick();
        wr0_valid = 0;
        checks++; if (write_pointer !== 5'd0) begin failures++; $display("FAIL refill_wptr got=%0h exp=0", write_pointer); end
        rd_req_valid = 1;
        tick();
        rd_req_valid = 0;
        checks++; if (read_pointer !== 5'd0) begin failures++; $display("FAIL refill_rptr got=%0h exp=0", read_pointer); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL refill_valid got=%0h exp=1", rd_valid); end
        checks++; if (rd_data !== {4'd6, 32'd22, 32'd44}) begin failures++; $display("FAIL refill_data got=%0h exp=%0h", rd_data, {4'd6, 32'd22, 32'd44}); end
        rd_ready = 1;
        tick();
        rd_ready = 0;
        checks++; if (count !== 6'd0) begin failures++; $display("FAIL refill_count got=%0h exp=0", count); end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_wr0_only();
        test_arbitration();
        test_full_wrap();
        test_read_backpressure();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
